// File: rtl/gsr_reset_sequencer_pkg.sv
// Shared types and constants for the global reset sequencer.
// The optional EXT_RSTN debounce is selected with RST_DEBOUNCE_EN.
package gsr_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    GSR_REL = 2'd1,
    DOM     = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_EXT  = 2'd1;
  localparam logic [1:0] CAUSE_SOFT = 2'd2;
  localparam logic [1:0] CAUSE_WDT  = 2'd3;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gsr_reset_sequencer_if.sv
// Request/status bundle between the reset sources and the global reset sequencer.
// Optional EXT_RSTN debounce (RST_DEBOUNCE_EN) does not change this interface.
interface gsr_reset_sequencer_if #(
  parameter int unsigned N_DOMAINS = 4
);
  logic                 EXT_RSTN;
  logic                 SOFT_RST;
  logic                 WDT_EXP;
  logic                 CAUSE_CLR;
  logic                 GSR_N;
  logic [N_DOMAINS-1:0] DOMAIN_RSTN;
  logic                 BUSY;
  logic [3:0]           RST_CAUSE;

  modport master (
    output EXT_RSTN, SOFT_RST, WDT_EXP, CAUSE_CLR,
    input  GSR_N, DOMAIN_RSTN, BUSY, RST_CAUSE
  );

  modport slave (
    input  EXT_RSTN, SOFT_RST, WDT_EXP, CAUSE_CLR,
    output GSR_N, DOMAIN_RSTN, BUSY, RST_CAUSE
  );
endinterface

// File: rtl/gsr_reset_sequencer_rst_sync_debounce.sv
// Two-flop synchronizer for the external reset pin, with an optional debounce
// filter enabled by RST_DEBOUNCE_EN. req is high while the filtered pin is low.
module rst_sync_debounce
`ifdef RST_DEBOUNCE_EN
  #(parameter int unsigned DEBOUNCE_CYCLES = 8)
`endif
  (
  input  logic clk,
  input  logic rst_n,
  input  logic async_n,
  output logic req
);

  logic s1, s2;

  // Synchronizer resets to the released level so POR timing is not stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= async_n;
      s2 <= s1;
    end
  end

`ifdef RST_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DB_W-1:0] db_cnt;
  logic            db_lvl;

  // db_lvl follows s2 only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_lvl <= 1'b1;
    end else if (s2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= s2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign req = ~db_lvl;
`else
  assign req = ~s2;
`endif

endmodule

// File: rtl/gsr_reset_sequencer.sv
// Global reset sequencer: merges POR/pin/soft/watchdog requests, holds GSR_N low,
// then releases domain resets in order. RST_DEBOUNCE_EN adds EXT_RSTN debounce.
module gsr_reset_sequencer
  import gsr_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS       = 4,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input logic                  CLK,
  input logic                  RSTN,
  gsr_reset_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES) + 1);
  localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 gsr_n_q;
  logic [N_DOMAINS-1:0] dom_q;
  logic                 busy_q;
  logic [3:0]           cause_q;
  logic [3:0]           cause_set;
  logic                 req_ext;
  logic                 soft_q;
  logic                 wdt_q;
  logic                 req;

  rst_sync_debounce
`ifdef RST_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_ext_sync (
    .clk     (CLK),
    .rst_n   (RSTN),
    .async_n (bus.EXT_RSTN),
    .req     (req_ext)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      soft_q <= 1'b0;
      wdt_q  <= 1'b0;
    end else begin
      soft_q <= bus.SOFT_RST;
      wdt_q  <= bus.WDT_EXP;
    end
  end

  assign req = req_ext | soft_q | wdt_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= ASSERT;
      cnt     <= '0;
      idx     <= '0;
      gsr_n_q <= 1'b0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
    end else if (req) begin
      state   <= ASSERT;
      cnt     <= '0;
      idx     <= '0;
      gsr_n_q <= 1'b0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt     <= '0;
            gsr_n_q <= 1'b1;
            state   <= GSR_REL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GSR_REL: begin
          if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
            cnt      <= '0;
            dom_q[0] <= 1'b1;
            idx      <= IDX_W'(1);
            if (N_DOMAINS == 1) begin
              busy_q <= 1'b0;
              state  <= RUN;
            end else begin
              state <= DOM;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOM: begin
          if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
            cnt        <= '0;
            dom_q[idx] <= 1'b1;
            if (idx == IDX_W'(N_DOMAINS - 1)) begin
              busy_q <= 1'b0;
              state  <= RUN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
        end
        default: state <= ASSERT;
      endcase
    end
  end

  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_EXT]  = req_ext;
    cause_set[CAUSE_SOFT] = soft_q;
    cause_set[CAUSE_WDT]  = wdt_q;
  end

  // A request landing on the clear cycle survives the clear.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cause_q <= 4'b0001;
    end else begin
      cause_q <= (bus.CAUSE_CLR ? 4'b0000 : cause_q) | cause_set;
    end
  end

  assign bus.GSR_N       = gsr_n_q;
  assign bus.DOMAIN_RSTN = dom_q;
  assign bus.BUSY        = busy_q;
  assign bus.RST_CAUSE   = cause_q;

endmodule

// File: tb/tb_gsr_reset_sequencer.sv
// Directed self-checking bench for gsr_reset_sequencer; expectations follow
// RST_DEBOUNCE_EN when it is defined for the build.
module tb_gsr_reset_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned STAG  = 4;
  localparam int unsigned DEB   = 8;
`ifdef RST_DEBOUNCE_EN
  localparam int EXT_LAT = 2 + DEB;
`else
  localparam int EXT_LAT = 2;
`endif

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  gsr_reset_sequencer_if #(.N_DOMAINS(N)) bus ();

  gsr_reset_sequencer #(
    .N_DOMAINS      (N),
    .HOLD_CYCLES    (HOLD),
    .STAGGER_CYCLES (STAG),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // {GSR_N, DOMAIN_RSTN[3:0], BUSY} expected e edges after the last request edge.
  function automatic logic [5:0] seq_exp(input int e);
    logic [3:0] d;
    for (int k = 0; k < 4; k++) d[k] = (e >= int'(HOLD + STAG * (k + 1)));
    return {(e >= int'(HOLD)), d, (e < int'(HOLD + STAG * N))};
  endfunction

  function automatic logic [5:0] obs();
    return {bus.GSR_N, bus.DOMAIN_RSTN, bus.BUSY};
  endfunction

  task automatic wait_run();
    for (int i = 0; i < 200 && bus.BUSY !== 1'b0; i++) tick();
    n_checks++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_run: BUSY=%b required 0 within 200 cycles", bus.BUSY);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (obs() !== 6'b0_0000_1 || bus.RST_CAUSE !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_state: outs=%b cause=%b required 000001 0001", obs(), bus.RST_CAUSE);
    end
    RSTN = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      tick();
      n_checks++;
      if (obs() !== seq_exp(e)) begin
        n_fail++;
        $display("FAIL por_seq e=%0d: outs=%b required %b", e, obs(), seq_exp(e));
      end
    end
    n_checks++;
    if (bus.RST_CAUSE !== 4'b0001) begin
      n_fail++;
      $display("FAIL por_cause: cause=%b required 0001", bus.RST_CAUSE);
    end
  endtask

  task automatic test_wdt();
    bus.WDT_EXP = 1'b1;
    tick();
    bus.WDT_EXP = 1'b0;
    n_checks++;
    if (obs() !== 6'b1_1111_0) begin
      n_fail++;
      $display("FAIL wdt_latency: outs=%b required 111110", obs());
    end
    tick();
    n_checks++;
    if (obs() !== 6'b0_0000_1 || bus.RST_CAUSE !== 4'b1001) begin
      n_fail++;
      $display("FAIL wdt_assert: outs=%b cause=%b required 000001 1001", obs(), bus.RST_CAUSE);
    end
    for (int e = 1; e <= 32; e++) begin
      tick();
      n_checks++;
      if (obs() !== seq_exp(e)) begin
        n_fail++;
        $display("FAIL wdt_seq e=%0d: outs=%b required %b", e, obs(), seq_exp(e));
      end
    end
    bus.CAUSE_CLR = 1'b1;
    tick();
    bus.CAUSE_CLR = 1'b0;
    n_checks++;
    if (bus.RST_CAUSE !== 4'b0000) begin
      n_fail++;
      $display("FAIL cause_clr: cause=%b required 0000", bus.RST_CAUSE);
    end
  endtask

  task automatic test_soft_in_dom();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    repeat (25) tick();
    n_checks++;
    if (obs() !== 6'b1_0011_1) begin
      n_fail++;
      $display("FAIL soft_pre: outs=%b required 100111", obs());
    end
    bus.SOFT_RST = 1'b1;
    tick();
    bus.SOFT_RST = 1'b0;
    n_checks++;
    if (obs() !== seq_exp(26)) begin
      n_fail++;
      $display("FAIL soft_latency: outs=%b required %b", obs(), seq_exp(26));
    end
    tick();
    n_checks++;
    if (obs() !== 6'b0_0000_1 || bus.RST_CAUSE !== 4'b0101) begin
      n_fail++;
      $display("FAIL soft_assert: outs=%b cause=%b required 000001 0101", obs(), bus.RST_CAUSE);
    end
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks++;
      if (obs() !== seq_exp(e)) begin
        n_fail++;
        $display("FAIL soft_restart e=%0d: outs=%b required %b", e, obs(), seq_exp(e));
      end
    end
    wait_run();
  endtask

  task automatic test_set_vs_clear();
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    bus.SOFT_RST  = 1'b1;
    bus.CAUSE_CLR = 1'b1;
    tick();
    bus.SOFT_RST  = 1'b0;
    bus.CAUSE_CLR = 1'b0;
    tick();
    n_checks++;
    if (bus.RST_CAUSE !== 4'b0100) begin
      n_fail++;
      $display("FAIL soft_and_clr: cause=%b required 0100", bus.RST_CAUSE);
    end
    bus.WDT_EXP = 1'b1;
    tick();
    bus.WDT_EXP   = 1'b0;
    bus.CAUSE_CLR = 1'b1;
    tick();
    bus.CAUSE_CLR = 1'b0;
    n_checks++;
    if (bus.RST_CAUSE !== 4'b1000) begin
      n_fail++;
      $display("FAIL set_wins_clr: cause=%b required 1000", bus.RST_CAUSE);
    end
    wait_run();
  endtask

  task automatic test_ext_hold();
    bus.CAUSE_CLR = 1'b1;
    tick();
    bus.CAUSE_CLR = 1'b0;
    bus.EXT_RSTN  = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      n_checks++;
      if (bus.GSR_N !== (t < EXT_LAT + 1)) begin
        n_fail++;
        $display("FAIL ext_hold t=%0d: GSR_N=%b required %b", t, bus.GSR_N, (t < EXT_LAT + 1));
      end
    end
    bus.EXT_RSTN = 1'b1;
    for (int t = 41; t <= 40 + EXT_LAT + 20; t++) begin
      tick();
      n_checks++;
      if (bus.GSR_N !== (t >= 40 + EXT_LAT + 16)) begin
        n_fail++;
        $display("FAIL ext_release t=%0d: GSR_N=%b required %b", t, bus.GSR_N,
                 (t >= 40 + EXT_LAT + 16));
      end
    end
    n_checks++;
    if (bus.RST_CAUSE !== 4'b0010) begin
      n_fail++;
      $display("FAIL ext_cause: cause=%b required 0010", bus.RST_CAUSE);
    end
    wait_run();
  endtask

  task automatic test_ext_debounce();
    logic exp_gsr;
    bus.CAUSE_CLR = 1'b1;
    tick();
    bus.CAUSE_CLR = 1'b0;
    bus.EXT_RSTN  = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 5) bus.EXT_RSTN = 1'b1;
`ifdef RST_DEBOUNCE_EN
      exp_gsr = 1'b1;
`else
      exp_gsr = !(t >= 3 && t < 23);
`endif
      n_checks++;
      if (bus.GSR_N !== exp_gsr) begin
        n_fail++;
        $display("FAIL glitch t=%0d: GSR_N=%b required %b", t, bus.GSR_N, exp_gsr);
      end
    end
    n_checks++;
`ifdef RST_DEBOUNCE_EN
    if (bus.RST_CAUSE !== 4'b0000) begin
      n_fail++;
      $display("FAIL glitch_cause: cause=%b required 0000", bus.RST_CAUSE);
    end
`else
    if (bus.RST_CAUSE !== 4'b0010) begin
      n_fail++;
      $display("FAIL glitch_cause: cause=%b required 0010", bus.RST_CAUSE);
    end
`endif
    wait_run();
    bus.CAUSE_CLR = 1'b1;
    tick();
    bus.CAUSE_CLR = 1'b0;
    bus.EXT_RSTN  = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      n_checks++;
      if (bus.GSR_N !== (t < EXT_LAT + 1)) begin
        n_fail++;
        $display("FAIL long_low t=%0d: GSR_N=%b required %b", t, bus.GSR_N, (t < EXT_LAT + 1));
      end
    end
    bus.EXT_RSTN = 1'b1;
    n_checks++;
    if (bus.RST_CAUSE !== 4'b0010) begin
      n_fail++;
      $display("FAIL long_low_cause: cause=%b required 0010", bus.RST_CAUSE);
    end
    wait_run();
  endtask

  initial begin
    bus.EXT_RSTN  = 1'b1;
    bus.SOFT_RST  = 1'b0;
    bus.WDT_EXP   = 1'b0;
    bus.CAUSE_CLR = 1'b0;
    test_reset();
    test_wdt();
    test_soft_in_dom();
    test_set_vs_clear();
    test_ext_hold();
    test_ext_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
